// File: rtl/ot_axi_dw_upsizer.sv
// 32-to-64-bit single-beat AXI upsizer with outstanding-transaction caps.
// Unsupported requests (bursts, size > 4 B) are answered locally with SLVERR.
package ot_axi_dw_upsizer_pkg;

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [0:0]  user;
  } slv_w_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } mst_w_chan_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } slv_r_chan_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } mst_r_chan_t;

  typedef struct packed {
    ax_chan_t    aw;
    logic        aw_valid;
    slv_w_chan_t w;
    logic        w_valid;
    logic        b_ready;
    ax_chan_t    ar;
    logic        ar_valid;
    logic        r_ready;
  } synth_ot_axi_out_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    b_chan_t     b;
    logic        r_valid;
    slv_r_chan_t r;
  } synth_ot_axi_out_resp_t;

  typedef struct packed {
    ax_chan_t    aw;
    logic        aw_valid;
    mst_w_chan_t w;
    logic        w_valid;
    logic        b_ready;
    ax_chan_t    ar;
    logic        ar_valid;
    logic        r_ready;
  } synth_axi_out_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    b_chan_t     b;
    logic        r_valid;
    mst_r_chan_t r;
  } synth_axi_out_resp_t;

endpackage

module ot_axi_dw_upsizer
  import ot_axi_dw_upsizer_pkg::*;
#(
  parameter int unsigned MaxTrans = 2,
  parameter type slv_req_t  = synth_ot_axi_out_req_t,
  parameter type slv_resp_t = synth_ot_axi_out_resp_t,
  parameter type mst_req_t  = synth_axi_out_req_t,
  parameter type mst_resp_t = synth_axi_out_resp_t
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  slv_req_t                       slv_req_i,
  output slv_resp_t                      slv_resp_o,
  output mst_req_t                       mst_req_o,
  input  mst_resp_t                      mst_resp_i,
  output logic [$clog2(MaxTrans+1)-1:0]  rd_outstanding_o,
  output logic [$clog2(MaxTrans+1)-1:0]  wr_outstanding_o
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxTrans);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_DRAIN, W_ERRB} w_state_e;
  typedef enum logic {R_IDLE, R_ERR} r_state_e;

  w_state_e        wState_q, wState_d;
  r_state_e        rState_q, rState_d;
  logic [CntW-1:0] wrCnt_q, wrCnt_d, rdCnt_q, rdCnt_d;
  logic            wLane_q, wLane_d;
  logic [7:0]      wErrId_q, wErrId_d, rErrId_q, rErrId_d, rdId_q, rdId_d;
  logic [8:0]      rBeats_q, rBeats_d;
  logic            laneFifo_q [MaxTrans];
  logic            laneFifo_d [MaxTrans];
  logic [PtrW-1:0] wPtr_q, wPtr_d, rPtr_q, rPtr_d;
  logic            wrInc, wrDec, rdInc, rdDec;
  logic            awLegal, arLegal, wrGate, rdGate;

  assign awLegal = (slv_req_i.aw.len == 8'd0) && (slv_req_i.aw.size <= 3'd2);
  assign arLegal = (slv_req_i.ar.len == 8'd0) && (slv_req_i.ar.size <= 3'd2);
  assign wrGate  = wrCnt_q < MaxCnt;
  // Reads may only pile up behind an in-flight read of the same ID so responses stay ordered.
  assign rdGate  = (rdCnt_q < MaxCnt) && ((rdCnt_q == '0) || (slv_req_i.ar.id == rdId_q)) &&
                   (wState_q != W_ERRB);

  always_comb begin
    wState_d   = wState_q;
    rState_d   = rState_q;
    wLane_d    = wLane_q;
    wErrId_d   = wErrId_q;
    rErrId_d   = rErrId_q;
    rdId_d     = rdId_q;
    rBeats_d   = rBeats_q;
    laneFifo_d = laneFifo_q;
    wPtr_d     = wPtr_q;
    rPtr_d     = rPtr_q;
    wrCnt_d    = wrCnt_q;
    rdCnt_d    = rdCnt_q;
    wrInc      = 1'b0;
    wrDec      = 1'b0;
    rdInc      = 1'b0;
    rdDec      = 1'b0;
    mst_req_o  = '0;
    slv_resp_o = '0;
    mst_req_o.aw = slv_req_i.aw;
    mst_req_o.ar = slv_req_i.ar;

    case (wState_q)
      W_IDLE: begin
        if (slv_req_i.aw_valid) begin
          if (awLegal) begin
            mst_req_o.aw_valid  = wrGate;
            slv_resp_o.aw_ready = mst_resp_i.aw_ready & wrGate;
            if (wrGate && mst_resp_i.aw_ready) begin
              wLane_d  = slv_req_i.aw.addr[2];
              wState_d = W_DATA;
              wrInc    = 1'b1;
            end
          end else begin
            slv_resp_o.aw_ready = 1'b1;
            wErrId_d = slv_req_i.aw.id;
            wState_d = W_DRAIN;
          end
        end
      end
      W_DATA: begin
        mst_req_o.w_valid  = slv_req_i.w_valid;
        slv_resp_o.w_ready = mst_resp_i.w_ready;
        mst_req_o.w.data   = wLane_q ? {slv_req_i.w.data, 32'h0} : {32'h0, slv_req_i.w.data};
        mst_req_o.w.strb   = wLane_q ? {slv_req_i.w.strb, 4'h0} : {4'h0, slv_req_i.w.strb};
        mst_req_o.w.last   = 1'b1;
        mst_req_o.w.user   = slv_req_i.w.user;
        if (slv_req_i.w_valid && mst_resp_i.w_ready) wState_d = W_IDLE;
      end
      W_DRAIN: begin
        slv_resp_o.w_ready = 1'b1;
        if (slv_req_i.w_valid && slv_req_i.w.last) wState_d = W_ERRB;
      end
      W_ERRB: begin
        slv_resp_o.b_valid = 1'b1;
        slv_resp_o.b.id    = wErrId_q;
        slv_resp_o.b.resp  = RespSlvErr;
        if (slv_req_i.b_ready) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase

    if (wState_q != W_ERRB) begin
      slv_resp_o.b       = mst_resp_i.b;
      slv_resp_o.b_valid = mst_resp_i.b_valid;
      mst_req_o.b_ready  = slv_req_i.b_ready;
      wrDec = mst_resp_i.b_valid & slv_req_i.b_ready;
    end

    case (rState_q)
      R_IDLE: begin
        if (slv_req_i.ar_valid) begin
          if (arLegal) begin
            mst_req_o.ar_valid  = rdGate;
            slv_resp_o.ar_ready = mst_resp_i.ar_ready & rdGate;
            if (rdGate && mst_resp_i.ar_ready) begin
              laneFifo_d[wPtr_q] = slv_req_i.ar.addr[2];
              wPtr_d = (wPtr_q == LastPtr) ? '0 : wPtr_q + 1'b1;
              rdId_d = slv_req_i.ar.id;
              rdInc  = 1'b1;
            end
          end else if (rdCnt_q == '0) begin
            slv_resp_o.ar_ready = 1'b1;
            rErrId_d = slv_req_i.ar.id;
            rBeats_d = {1'b0, slv_req_i.ar.len} + 9'd1;
            rState_d = R_ERR;
          end
        end
        slv_resp_o.r_valid = mst_resp_i.r_valid;
        slv_resp_o.r.id    = mst_resp_i.r.id;
        slv_resp_o.r.data  = laneFifo_q[rPtr_q] ? mst_resp_i.r.data[63:32] : mst_resp_i.r.data[31:0];
        slv_resp_o.r.resp  = mst_resp_i.r.resp;
        slv_resp_o.r.last  = mst_resp_i.r.last;
        slv_resp_o.r.user  = mst_resp_i.r.user;
        mst_req_o.r_ready  = slv_req_i.r_ready;
        rdDec = mst_resp_i.r_valid & slv_req_i.r_ready;
        if (rdDec && rdCnt_q != '0) rPtr_d = (rPtr_q == LastPtr) ? '0 : rPtr_q + 1'b1;
      end
      R_ERR: begin
        slv_resp_o.r_valid = 1'b1;
        slv_resp_o.r.id    = rErrId_q;
        slv_resp_o.r.resp  = RespSlvErr;
        slv_resp_o.r.last  = (rBeats_q == 9'd1);
        if (slv_req_i.r_ready) begin
          rBeats_d = rBeats_q - 9'd1;
          if (rBeats_q == 9'd1) rState_d = R_IDLE;
        end
      end
      default: rState_d = R_IDLE;
    endcase

    // A response arriving with nothing outstanding is ignored so the count cannot wrap.
    if (wrInc && !wrDec) wrCnt_d = wrCnt_q + 1'b1;
    else if (wrDec && !wrInc && wrCnt_q != '0) wrCnt_d = wrCnt_q - 1'b1;
    if (rdInc && !rdDec) rdCnt_d = rdCnt_q + 1'b1;
    else if (rdDec && !rdInc && rdCnt_q != '0) rdCnt_d = rdCnt_q - 1'b1;

    if (rst_i) begin
      mst_req_o  = '0;
      slv_resp_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wState_q <= W_IDLE;
      rState_q <= R_IDLE;
      wrCnt_q  <= '0;
      rdCnt_q  <= '0;
      wLane_q  <= 1'b0;
      wErrId_q <= '0;
      rErrId_q <= '0;
      rdId_q   <= '0;
      rBeats_q <= '0;
      wPtr_q   <= '0;
      rPtr_q   <= '0;
      for (int i = 0; i < MaxTrans; i++) laneFifo_q[i] <= 1'b0;
    end else begin
      wState_q   <= wState_d;
      rState_q   <= rState_d;
      wrCnt_q    <= wrCnt_d;
      rdCnt_q    <= rdCnt_d;
      wLane_q    <= wLane_d;
      wErrId_q   <= wErrId_d;
      rErrId_q   <= rErrId_d;
      rdId_q     <= rdId_d;
      rBeats_q   <= rBeats_d;
      wPtr_q     <= wPtr_d;
      rPtr_q     <= rPtr_d;
      laneFifo_q <= laneFifo_d;
    end
  end

  assign rd_outstanding_o = rdCnt_q;
  assign wr_outstanding_o = wrCnt_q;

  wrUnderflow: assert property (@(posedge clk_i) disable iff (rst_i) !(wrDec && wrCnt_q == '0));
  rdUnderflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                !(rdDec && rState_q == R_IDLE && rdCnt_q == '0));

endmodule

// File: tb/tb_ot_axi_dw_upsizer.sv
// Bench for ot_axi_dw_upsizer: directed scenarios plus randomized single-beat traffic
// checked against a queue-based model of lane selection and outstanding limits.
module tb_ot_axi_dw_upsizer;
  import ot_axi_dw_upsizer_pkg::*;

  localparam int unsigned MaxTrans = 2;

  logic clk = 1'b0;
  logic rst;
  synth_ot_axi_out_req_t  slvReq;
  synth_ot_axi_out_resp_t slvResp;
  synth_axi_out_req_t     mstReq;
  synth_axi_out_resp_t    mstResp;
  logic [1:0] rdOut, wrOut;

  int checkCnt = 0;
  int passCnt = 0;
  int failCnt = 0;
  logic laneQ[$];
  logic [7:0] lastRdId = '0;

  always #5 clk = ~clk;

  ot_axi_dw_upsizer #(.MaxTrans(MaxTrans)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slvReq), .slv_resp_o(slvResp),
    .mst_req_o(mstReq), .mst_resp_i(mstResp),
    .rd_outstanding_o(rdOut), .wr_outstanding_o(wrOut)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus();
    slvReq  = '0;
    mstResp = '0;
  endtask

  // Full legal write; expected lane placement is computed as a shift by the word offset.
  task automatic writeTxn(input logic [63:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [7:0] id, input logic [1:0] bResp);
    logic [63:0] expData;
    logic [7:0]  expStrb;
    expData = {32'h0, data} << (32 * int'(addr[2]));
    expStrb = {4'h0, strb} << (4 * int'(addr[2]));
    slvReq.aw = '0;
    slvReq.aw.id = id;
    slvReq.aw.addr = addr;
    slvReq.aw.size = 3'd2;
    slvReq.aw.burst = 2'b01;
    slvReq.aw_valid = 1'b1;
    mstResp.aw_ready = 1'b1;
    settle();
    checkOutput("aw_fwd_valid", 64'(mstReq.aw_valid), 64'd1);
    checkOutput("aw_ready", 64'(slvResp.aw_ready), 64'd1);
    checkOutput("aw_addr", mstReq.aw.addr, addr);
    tick();
    slvReq.aw_valid = 1'b0;
    mstResp.aw_ready = 1'b0;
    checkOutput("wr_outstanding_1", 64'(wrOut), 64'd1);
    slvReq.w.data = data;
    slvReq.w.strb = strb;
    slvReq.w.last = 1'b1;
    slvReq.w_valid = 1'b1;
    mstResp.w_ready = 1'b1;
    settle();
    checkOutput("w_fwd_valid", 64'(mstReq.w_valid), 64'd1);
    checkOutput("w_data", mstReq.w.data, expData);
    checkOutput("w_strb", 64'(mstReq.w.strb), 64'(expStrb));
    checkOutput("w_last", 64'(mstReq.w.last), 64'd1);
    tick();
    slvReq.w_valid = 1'b0;
    mstResp.w_ready = 1'b0;
    mstResp.b_valid = 1'b1;
    mstResp.b.id = id;
    mstResp.b.resp = bResp;
    slvReq.b_ready = 1'b1;
    settle();
    checkOutput("b_valid", 64'(slvResp.b_valid), 64'd1);
    checkOutput("b_id", 64'(slvResp.b.id), 64'(id));
    checkOutput("b_resp", 64'(slvResp.b.resp), 64'(bResp));
    tick();
    mstResp.b_valid = 1'b0;
    slvReq.b_ready = 1'b0;
    checkOutput("wr_outstanding_0", 64'(wrOut), 64'd0);
  endtask

  task automatic issueAr(input logic [7:0] id, input logic [63:0] addr);
    logic expAccept;
    expAccept = (laneQ.size() < MaxTrans) && (laneQ.size() == 0 || id == lastRdId);
    slvReq.ar = '0;
    slvReq.ar.id = id;
    slvReq.ar.addr = addr;
    slvReq.ar.size = 3'd2;
    slvReq.ar_valid = 1'b1;
    mstResp.ar_ready = 1'b1;
    settle();
    checkOutput("ar_ready", 64'(slvResp.ar_ready), 64'(expAccept));
    checkOutput("ar_fwd_valid", 64'(mstReq.ar_valid), 64'(expAccept));
    tick();
    slvReq.ar_valid = 1'b0;
    mstResp.ar_ready = 1'b0;
    if (expAccept) begin
      laneQ.push_back(addr[2]);
      lastRdId = id;
    end
    checkOutput("rd_outstanding", 64'(rdOut), 64'(laneQ.size()));
  endtask

  task automatic returnR(input logic [63:0] rdata, input logic [7:0] id);
    logic [31:0] expData;
    expData = 32'(rdata >> (32 * int'(laneQ[0])));
    mstResp.r_valid = 1'b1;
    mstResp.r.data = rdata;
    mstResp.r.id = id;
    mstResp.r.resp = 2'b00;
    mstResp.r.last = 1'b1;
    slvReq.r_ready = 1'b1;
    settle();
    checkOutput("r_valid", 64'(slvResp.r_valid), 64'd1);
    checkOutput("r_data", 64'(slvResp.r.data), 64'(expData));
    checkOutput("r_id", 64'(slvResp.r.id), 64'(id));
    tick();
    mstResp.r_valid = 1'b0;
    slvReq.r_ready = 1'b0;
    void'(laneQ.pop_front());
    checkOutput("rd_outstanding", 64'(rdOut), 64'(laneQ.size()));
  endtask

  initial begin
    logic [63:0] rnd;
    rst = 1'b1;
    applyStimulus();
    tick();
    tick();
    checkOutput("reset_rd_out", 64'(rdOut), 64'd0);
    checkOutput("reset_wr_out", 64'(wrOut), 64'd0);
    checkOutput("reset_aw_valid", 64'(mstReq.aw_valid), 64'd0);
    rst = 1'b0;
    settle();
    checkOutput("idle_aw_ready", 64'(slvResp.aw_ready), 64'd0);
    checkOutput("idle_ar_ready", 64'(slvResp.ar_ready), 64'd0);

    $display("[TB] W beat without AW is held");
    slvReq.w.data = 32'hCAFE_F00D;
    slvReq.w_valid = 1'b1;
    mstResp.w_ready = 1'b1;
    settle();
    checkOutput("w_held_ready", 64'(slvResp.w_ready), 64'd0);
    checkOutput("w_held_fwd", 64'(mstReq.w_valid), 64'd0);
    applyStimulus();
    tick();

    $display("[TB] directed upper-lane write");
    writeTxn(64'h1000_0004, 32'hDEAD_BEEF, 4'hF, 8'h01, 2'b00);

    $display("[TB] random writes");
    for (int i = 0; i < 8; i++) begin
      rnd = {$urandom, $urandom};
      writeTxn({rnd[63:3], 1'($urandom_range(0, 1)), 2'b00}, $urandom, 4'($urandom),
               8'($urandom), 2'($urandom));
    end

    $display("[TB] two reads id 3 at offsets 0 and 4");
    issueAr(8'd3, 64'h0);
    issueAr(8'd3, 64'h4);
    returnR(64'h1111_2222_3333_4444, 8'd3);
    returnR(64'h1111_2222_3333_4444, 8'd3);

    $display("[TB] third AR held at cap");
    issueAr(8'd7, 64'h0);
    issueAr(8'd7, 64'h4);
    slvReq.ar.id = 8'd7;
    slvReq.ar.addr = 64'h0;
    slvReq.ar_valid = 1'b1;
    mstResp.ar_ready = 1'b1;
    settle();
    checkOutput("ar_held_cap", 64'(slvResp.ar_ready), 64'd0);
    checkOutput("rd_out_cap", 64'(rdOut), 64'd2);
    mstResp.r_valid = 1'b1;
    mstResp.r.data = 64'hAAAA_BBBB_CCCC_DDDD;
    mstResp.r.id = 8'd7;
    mstResp.r.last = 1'b1;
    slvReq.r_ready = 1'b1;
    settle();
    checkOutput("ar_held_same_cycle", 64'(slvResp.ar_ready), 64'd0);
    checkOutput("r_data_cap", 64'(slvResp.r.data), 64'h0000_0000_CCCC_DDDD);
    tick();
    void'(laneQ.pop_front());
    mstResp.r_valid = 1'b0;
    slvReq.r_ready = 1'b0;
    settle();
    checkOutput("ar_released", 64'(slvResp.ar_ready), 64'd1);
    checkOutput("ar_released_fwd", 64'(mstReq.ar_valid), 64'd1);
    tick();
    slvReq.ar_valid = 1'b0;
    mstResp.ar_ready = 1'b0;
    laneQ.push_back(1'b0);
    checkOutput("rd_out_after_swap", 64'(rdOut), 64'd2);
    returnR(64'h5555_6666_7777_8888, 8'd7);
    returnR(64'h9999_AAAA_BBBB_CCCC, 8'd7);

    $display("[TB] AR with different id waits for in-flight read");
    issueAr(8'd3, 64'h4);
    slvReq.ar.id = 8'd5;
    slvReq.ar.addr = 64'h0;
    slvReq.ar_valid = 1'b1;
    mstResp.ar_ready = 1'b1;
    mstResp.r_valid = 1'b1;
    mstResp.r.data = 64'h0123_4567_89AB_CDEF;
    mstResp.r.id = 8'd3;
    mstResp.r.last = 1'b1;
    slvReq.r_ready = 1'b1;
    settle();
    checkOutput("ar_id_held", 64'(slvResp.ar_ready), 64'd0);
    checkOutput("r_data_id3", 64'(slvResp.r.data), 64'h0123_4567);
    tick();
    void'(laneQ.pop_front());
    mstResp.r_valid = 1'b0;
    slvReq.r_ready = 1'b0;
    settle();
    checkOutput("ar_id_released", 64'(slvResp.ar_ready), 64'd1);
    tick();
    slvReq.ar_valid = 1'b0;
    mstResp.ar_ready = 1'b0;
    laneQ.push_back(1'b0);
    lastRdId = 8'd5;
    returnR(64'hFEDC_BA98_7654_3210, 8'd5);

    $display("[TB] random reads");
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        rnd = {$urandom, $urandom};
        issueAr(8'($urandom_range(2, 3)), {rnd[63:3], 1'($urandom_range(0, 1)), 2'b00});
      end
      while (laneQ.size() > 0) returnR({$urandom, $urandom}, lastRdId);
    end

    $display("[TB] illegal write drained locally");
    slvReq.aw = '0;
    slvReq.aw.id = 8'h42;
    slvReq.aw.len = 8'd3;
    slvReq.aw.size = 3'd2;
    slvReq.aw_valid = 1'b1;
    mstResp.aw_ready = 1'b1;
    settle();
    checkOutput("ill_aw_ready", 64'(slvResp.aw_ready), 64'd1);
    checkOutput("ill_aw_fwd", 64'(mstReq.aw_valid), 64'd0);
    tick();
    applyStimulus();
    for (int beat = 0; beat < 4; beat++) begin
      slvReq.w_valid = 1'b1;
      slvReq.w.data = $urandom;
      slvReq.w.last = (beat == 3);
      mstResp.w_ready = 1'b1;
      settle();
      checkOutput("ill_w_ready", 64'(slvResp.w_ready), 64'd1);
      checkOutput("ill_w_fwd", 64'(mstReq.w_valid), 64'd0);
      checkOutput("ill_b_early", 64'(slvResp.b_valid), 64'd0);
      tick();
    end
    applyStimulus();
    settle();
    checkOutput("ill_b_valid", 64'(slvResp.b_valid), 64'd1);
    checkOutput("ill_b_resp", 64'(slvResp.b.resp), 64'd2);
    checkOutput("ill_b_id", 64'(slvResp.b.id), 64'h42);
    checkOutput("ill_b_mst_ready", 64'(mstReq.b_ready), 64'd0);
    slvReq.b_ready = 1'b1;
    tick();
    slvReq.b_ready = 1'b0;
    settle();
    checkOutput("ill_b_done", 64'(slvResp.b_valid), 64'd0);
    checkOutput("ill_wr_out", 64'(wrOut), 64'd0);

    $display("[TB] illegal read answered locally");
    slvReq.ar = '0;
    slvReq.ar.id = 8'd9;
    slvReq.ar.len = 8'd1;
    slvReq.ar.size = 3'd3;
    slvReq.ar_valid = 1'b1;
    mstResp.ar_ready = 1'b1;
    settle();
    checkOutput("ill_ar_ready", 64'(slvResp.ar_ready), 64'd1);
    checkOutput("ill_ar_fwd", 64'(mstReq.ar_valid), 64'd0);
    tick();
    applyStimulus();
    slvReq.r_ready = 1'b1;
    for (int beat = 0; beat < 2; beat++) begin
      settle();
      checkOutput("ill_r_valid", 64'(slvResp.r_valid), 64'd1);
      checkOutput("ill_r_resp", 64'(slvResp.r.resp), 64'd2);
      checkOutput("ill_r_data", 64'(slvResp.r.data), 64'd0);
      checkOutput("ill_r_id", 64'(slvResp.r.id), 64'd9);
      checkOutput("ill_r_last", 64'(slvResp.r.last), 64'(beat == 1));
      checkOutput("ill_r_mst_ready", 64'(mstReq.r_ready), 64'd0);
      tick();
    end
    slvReq.r_ready = 1'b0;
    issueAr(8'd4, 64'h4);
    returnR(64'h7777_0000_0000_1111, 8'd4);

    $display("[TB] reset with two reads outstanding");
    issueAr(8'd1, 64'h0);
    issueAr(8'd1, 64'h4);
    checkOutput("pre_reset_rd_out", 64'(rdOut), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    laneQ.delete();
    settle();
    checkOutput("post_reset_rd_out", 64'(rdOut), 64'd0);
    checkOutput("post_reset_wr_out", 64'(wrOut), 64'd0);
    checkOutput("post_reset_valids",
                64'({mstReq.aw_valid, mstReq.w_valid, mstReq.ar_valid, slvResp.b_valid, slvResp.r_valid}),
                64'd0);
    issueAr(8'd2, 64'h4);
    returnR(64'h2222_3333_4444_5555, 8'd2);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
